// File: rtl/logic_op_pipe.sv
// WIDTH-bit bitwise logic unit with run-time op select, followed by STAGES
// valid/ready register slices carrying result, zero flag and ones count.
module logic_op_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_a,
  input  logic [WIDTH-1:0]             in_b,
  input  logic [2:0]                   in_op,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_y,
  output logic                         out_zero,
  output logic [$clog2(WIDTH+1)-1:0]   out_ones
);

  localparam int OW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  logic [WIDTH-1:0] res;
  logic [OW-1:0]    cnt;

  always_comb begin
    res = '0;
    case (op_e'(in_op))
      OP_AND:  res = in_a & in_b;
      OP_OR:   res = in_a | in_b;
      OP_XOR:  res = in_a ^ in_b;
      OP_NAND: res = ~(in_a & in_b);
      OP_NOR:  res = ~(in_a | in_b);
      OP_XNOR: res = ~(in_a ^ in_b);
      OP_NOT:  res = ~in_a;
      default: res = in_a;
    endcase
    cnt = '0;
    for (int unsigned i = 0; i < WIDTH; i++) cnt = cnt + OW'(res[i]);
  end

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] adv;
  logic [WIDTH-1:0]  y_q [STAGES];
  logic              z_q [STAGES];
  logic [OW-1:0]     n_q [STAGES];

  // Advance chain runs from the output back, so a full pipe moves as one when out_ready=1.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = !v[STAGES-1] || out_ready;
    for (int unsigned i = 1; i < STAGES; i++)
      adv[STAGES-1-i] = !v[STAGES-1-i] || adv[STAGES-i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        y_q[i] <= '0;
        z_q[i] <= 1'b0;
        n_q[i] <= '0;
      end
    end else begin
      if (adv[0]) begin
        v[0] <= in_valid;
        if (in_valid) begin
          y_q[0] <= res;
          z_q[0] <= (res == '0);
          n_q[0] <= cnt;
        end
      end
      for (int unsigned i = 1; i < STAGES; i++) begin
        if (adv[i]) begin
          v[i] <= v[i-1];
          if (v[i-1]) begin
            y_q[i] <= y_q[i-1];
            z_q[i] <= z_q[i-1];
            n_q[i] <= n_q[i-1];
          end
        end
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = v[STAGES-1];
  assign out_y     = y_q[STAGES-1];
  assign out_zero  = z_q[STAGES-1];
  assign out_ones  = n_q[STAGES-1];

endmodule

// File: tb/tb_logic_op_pipe.sv
// Scoreboard bench for logic_op_pipe: directed beats push expected results,
// a negedge monitor pops and compares whenever a result is delivered.
module tb_logic_op_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic [2:0] in_op = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_y;
  logic       out_zero;
  logic [3:0] out_ones;

  logic in_valid1 = 1'b0, in_ready1, in_a1 = 1'b0, in_b1 = 1'b0;
  logic [2:0] in_op1 = '0;
  logic out_valid1, out_y1, out_zero1, out_ones1;

  always #5 clk = ~clk;

  logic_op_pipe #(.WIDTH(8), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_y(out_y), .out_zero(out_zero), .out_ones(out_ones)
  );

  logic_op_pipe #(.WIDTH(1), .STAGES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .in_op(in_op1), .out_valid(out_valid1),
    .out_ready(1'b1), .out_y(out_y1), .out_zero(out_zero1), .out_ones(out_ones1)
  );

  typedef struct {
    logic [7:0] y;
    logic       z;
    logic [3:0] n;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   lat_chk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_beat actual=%0h required=none", out_y);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_y", out_y, e.y);
        chk("out_zero", out_zero, e.z);
        chk("out_ones", out_ones, e.n);
        if (lat_chk) chk("latency", cyc - e.acc, 2);
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      input logic [7:0] y, input logic z, input logic [3:0] n,
                      input bit push, output int waits);
    bit done;
    done = 1'b0;
    waits = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op;
    while (!done && waits < 50) begin
      @(negedge clk);
      if (in_ready) begin
        if (push) sb.push_back('{y: y, z: z, n: n, acc: cyc});
        done = 1'b1;
      end else begin
        waits++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  logic [7:0] tt_y [8] = '{8'h88, 8'hEE, 8'h66, 8'h77, 8'h11, 8'h99, 8'h33, 8'hCC};
  logic [3:0] tt_n [8] = '{4'd2, 4'd6, 4'd4, 4'd6, 4'd2, 4'd4, 4'd4, 4'd4};

  typedef struct {
    logic [7:0] a, b;
    logic [2:0] op;
    logic [7:0] y;
    logic       z;
    logic [3:0] n;
  } vec_t;

  vec_t st[6] = '{
    '{8'hFF, 8'h3C, 3'd0, 8'h3C, 1'b0, 4'd4},
    '{8'h01, 8'h80, 3'd1, 8'h81, 1'b0, 4'd2},
    '{8'hFF, 8'h0F, 3'd2, 8'hF0, 1'b0, 4'd4},
    '{8'hFF, 8'hFF, 3'd3, 8'h00, 1'b1, 4'd0},
    '{8'h00, 8'h00, 3'd4, 8'hFF, 1'b0, 4'd8},
    '{8'h5A, 8'h00, 3'd7, 8'h5A, 1'b0, 4'd4}
  };

  vec_t bp[5] = '{
    '{8'h0F, 8'h0F, 3'd5, 8'hFF, 1'b0, 4'd8},
    '{8'h0F, 8'h33, 3'd6, 8'hF0, 1'b0, 4'd4},
    '{8'hAA, 8'h0F, 3'd0, 8'h0A, 1'b0, 4'd2},
    '{8'h10, 8'h20, 3'd1, 8'h30, 1'b0, 4'd2},
    '{8'h55, 8'h55, 3'd2, 8'h00, 1'b1, 4'd0}
  };

  initial begin
    int w;
    int idx;

    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_out_zero", out_zero, 0);
    chk("rst_out_ones", out_ones, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst1_out_valid", out_valid1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    lat_chk = 1'b1;
    for (int i = 0; i < 8; i++)
      send(8'hCC, 8'hAA, 3'(i), tt_y[i], 1'b0, tt_n[i], 1'b1, w);
    drain();

    send(8'hF0, 8'h0F, 3'd0, 8'h00, 1'b1, 4'd0, 1'b1, w);
    send(8'hF0, 8'h0F, 3'd1, 8'hFF, 1'b0, 4'd8, 1'b1, w);
    drain();

    for (int i = 0; i < 6; i++) begin
      send(st[i].a, st[i].b, st[i].op, st[i].y, st[i].z, st[i].n, 1'b1, w);
      chk("stream_ready_waits", w, 0);
    end
    drain();
    lat_chk = 1'b0;

    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_a = bp[idx].a; in_b = bp[idx].b; in_op = bp[idx].op;
      @(negedge clk);
      if (out_valid) chk("bp_hold_y", out_y, 8'hFF);
      if (in_ready) begin
        sb.push_back('{y: bp[idx].y, z: bp[idx].z, n: bp[idx].n, acc: cyc});
        idx++;
      end
      @(posedge clk); #1;
      in_op = 3'd3;
    end
    in_valid = 1'b0;
    chk("bp_accepted", idx, 2);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    out_ready = 1'b1;
    for (int i = 2; i < 5; i++)
      send(bp[i].a, bp[i].b, bp[i].op, bp[i].y, bp[i].z, bp[i].n, 1'b1, w);
    drain();

    out_ready = 1'b0;
    send(8'h12, 8'h34, 3'd1, 8'h00, 1'b0, 4'd0, 1'b0, w);
    send(8'h56, 8'h78, 3'd2, 8'h00, 1'b0, 4'd0, 1'b0, w);
    @(negedge clk);
    chk("pre_reset_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_async_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("post_reset_in_ready", in_ready, 1);

    in_valid1 = 1'b1; in_a1 = 1'b1; in_b1 = 1'b0; in_op1 = 3'd5;
    @(negedge clk);
    chk("w1_in_ready", in_ready1, 1);
    @(posedge clk); #1;
    in_valid1 = 1'b0; in_a1 = 1'b0; in_op1 = 3'd0;
    @(negedge clk);
    chk("w1_out_valid", out_valid1, 1);
    chk("w1_out_y", out_y1, 0);
    chk("w1_out_zero", out_zero1, 1);
    chk("w1_out_ones", out_ones1, 0);
    @(negedge clk);
    chk("w1_out_valid_drop", out_valid1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
